// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//  NCH     : number of output channels (fixed at 4 in this revision)
//  SELW    : width of the destination select
//  sel2idx : maps in_sel to a channel index, matching the team's 4x1 mux
package demux_pkg;

   localparam int unsigned NCH  = 4;
   localparam int unsigned SELW = 2;

   // Channel index is the select with its bits swapped: 00->0, 10->1, 01->2, 11->3
   function automatic logic [SELW-1:0] sel2idx(input logic [SELW-1:0] sel);
      return {sel[0], sel[1]};
   endfunction

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry holding slot for a single demux output channel.
//  clk, rst_n : clock, async active-low reset
//  load       : write load_data into the slot this cycle
//  load_data  : payload to store
//  out_ready  : consumer ready
//  out_valid  : slot holds a beat (registered)
//  out_data   : stored payload, held after drain (registered)
//  can_load   : slot is empty or drains this cycle (combinational)
module demux_slot #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          can_load
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   // A drain and a load in the same cycle keep the slot full with new data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= load_data;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign can_load  = !r_valid || out_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;

endmodule : demux_slot

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on both sides.
// Each channel owns a one-entry slot, so a stalled consumer blocks only
// beats addressed to it.
// Optional build macro: DEMUX_PKT_LOCK_EN (hold the destination for a whole
// packet, delimited by in_last).
//  clk, rst_n : clock, async active-low reset
//  in_valid   : input beat valid
//  in_ready   : input beat accepted when in_valid & in_ready (combinational)
//  in_data    : input payload
//  in_sel     : destination select, sampled with the beat
//  in_last    : end-of-packet marker (packet-lock build only)
//  out_valid  : per-channel valid
//  out_ready  : per-channel ready
//  out_data   : channel k payload at [k*DW +: DW]
module demux_1x4_stream #(
   parameter int unsigned DW  = 8,
   parameter int unsigned NCH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   input  logic [1:0]        in_sel,
   input  logic              in_last,
   output logic [NCH-1:0]    out_valid,
   input  logic [NCH-1:0]    out_ready,
   output logic [NCH*DW-1:0] out_data
);

   import demux_pkg::*;

   logic [SELW-1:0] w_idx;
   logic [NCH-1:0]  w_can_load;
   logic            w_fire;

`ifdef DEMUX_PKT_LOCK_EN
   logic            r_locked;
   logic [SELW-1:0] r_lock_idx;

   // While locked the captured index overrides in_sel
   assign w_idx = r_locked ? r_lock_idx : sel2idx(in_sel);

   // Lock on the first beat of a multi-beat packet, release after its last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked   <= 1'b0;
         r_lock_idx <= '0;
      end else if (w_fire) begin
         if (!r_locked && !in_last) begin
            r_locked   <= 1'b1;
            r_lock_idx <= w_idx;
         end else if (r_locked && in_last) begin
            r_locked   <= 1'b0;
         end
      end
   end
`else
   logic w_unused_last;

   assign w_idx         = sel2idx(in_sel);
   assign w_unused_last = in_last;
`endif

   // Ready follows only the addressed slot, never in_valid
   assign in_ready = w_can_load[w_idx];
   assign w_fire   = in_valid && in_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_slot
      demux_slot #(.DW(DW)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (w_fire && (w_idx == SELW'(k))),
         .load_data (in_data),
         .out_ready (out_ready[k]),
         .out_valid (out_valid[k]),
         .out_data  (out_data[k*DW +: DW]),
         .can_load  (w_can_load[k])
      );
   end

endmodule : demux_1x4_stream

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream (DW=8, four channels).
// Expected values are hand-computed; the packet-lock section picks its
// expectations according to DEMUX_PKT_LOCK_EN.
module tb_demux_1x4_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_last;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        vld;
      logic [1:0]  sel;
      logic [7:0]  data;
      logic        last;
      logic [3:0]  ordy;
      logic        exp_rdy;
      logic [3:0]  exp_ov;
      logic [31:0] exp_od;
   } vec_t;

   vec_t vecs[$];

   demux_1x4_stream #(.DW(8), .NCH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                               input logic last, input logic [3:0] ordy, input logic exp_rdy,
                               input logic [3:0] exp_ov, input logic [31:0] exp_od);
      vec_t v;
      v.vld = vld; v.sel = sel; v.data = data; v.last = last; v.ordy = ordy;
      v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_od = exp_od;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                        input logic last, input logic [3:0] ordy);
      in_valid  = vld;
      in_sel    = sel;
      in_data   = data;
      in_last   = last;
      out_ready = ordy;
   endtask

   initial begin
      drive(1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
      rst_n = 1'b0;

      // Routing, back-pressure, isolation, ready independent of in_valid
      add(1, 2'b00, 8'hA1, 0, 4'hF, 1, 4'b0001, 32'h000000A1);
      add(1, 2'b10, 8'hB2, 0, 4'hF, 1, 4'b0010, 32'h0000B2A1);
      add(1, 2'b01, 8'hC3, 0, 4'hF, 1, 4'b0100, 32'h00C3B2A1);
      add(1, 2'b11, 8'hD4, 0, 4'hF, 1, 4'b1000, 32'hD4C3B2A1);
      add(0, 2'b00, 8'h00, 0, 4'hF, 1, 4'b0000, 32'hD4C3B2A1);
      add(1, 2'b00, 8'h11, 0, 4'hE, 1, 4'b0001, 32'hD4C3B211);
      add(1, 2'b00, 8'h22, 0, 4'hE, 0, 4'b0001, 32'hD4C3B211);
      add(0, 2'b00, 8'h22, 0, 4'hE, 0, 4'b0001, 32'hD4C3B211);
      add(1, 2'b11, 8'h33, 0, 4'hE, 1, 4'b1001, 32'h33C3B211);
      add(1, 2'b00, 8'h22, 0, 4'hF, 1, 4'b0001, 32'h33C3B222);
      add(0, 2'b00, 8'h00, 0, 4'hF, 1, 4'b0000, 32'h33C3B222);
      // Packet sequence: sel 01,00,11 last 0,0,1 then sel 00
`ifdef DEMUX_PKT_LOCK_EN
      add(1, 2'b01, 8'hC1, 0, 4'hF, 1, 4'b0100, 32'h33C1B222);
      add(1, 2'b00, 8'hC2, 0, 4'hF, 1, 4'b0100, 32'h33C2B222);
      add(1, 2'b11, 8'hC3, 1, 4'hF, 1, 4'b0100, 32'h33C3B222);
      add(1, 2'b00, 8'hC4, 1, 4'hF, 1, 4'b0001, 32'h33C3B2C4);
      add(0, 2'b00, 8'h00, 0, 4'hF, 1, 4'b0000, 32'h33C3B2C4);
`else
      add(1, 2'b01, 8'hC1, 0, 4'hF, 1, 4'b0100, 32'h33C1B222);
      add(1, 2'b00, 8'hC2, 0, 4'hF, 1, 4'b0001, 32'h33C1B2C2);
      add(1, 2'b11, 8'hC3, 1, 4'hF, 1, 4'b1000, 32'hC3C1B2C2);
      add(1, 2'b00, 8'hC4, 1, 4'hF, 1, 4'b0001, 32'hC3C1B2C4);
      add(0, 2'b00, 8'h00, 0, 4'hF, 1, 4'b0000, 32'hC3C1B2C4);
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_data", out_data, 32'h0);
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven vectors: ready checked before the edge, outputs after it
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].ordy);
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
      end

      // Throughput: 16 back-to-back beats to ch1 with its consumer always ready
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 2'b10, 8'(8'h40 + i), 1'b1, 4'hF);
         #1;
         chk($sformatf("tput%0d_in_ready", i), 32'(in_ready), 32'h1);
         @(posedge clk);
         #1;
         chk($sformatf("tput%0d_out_valid", i), 32'(out_valid), 32'b0010);
         chk($sformatf("tput%0d_ch1_data", i), 32'(out_data[15:8]), 32'(8'h40 + i));
      end

      // Mid-stream reset with ch2 full and stalled
      drive(1'b1, 2'b01, 8'h77, 1'b1, 4'b1011);
      @(posedge clk);
      #1;
      chk("prerst_out_valid", 32'(out_valid), 32'b0100);
      drive(1'b1, 2'b00, 8'h88, 1'b1, 4'b1011);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_out_data", out_data, 32'h0);
      drive(1'b0, 2'b01, 8'h00, 1'b0, 4'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("postrst_in_ready", 32'(in_ready), 32'h1);
      drive(1'b1, 2'b00, 8'h5A, 1'b1, 4'hF);
      @(posedge clk);
      #1;
      chk("postrst_out_valid", 32'(out_valid), 32'b0001);
      chk("postrst_out_data", out_data, 32'h0000005A);
      drive(1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
      @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_demux_1x4_stream
